// File: rtl/fr_normalizer.sv
// Post-add normalizer: renormalizes the raw mantissa sum, adjusts the exponent
// and packs an IEEE-754 single (truncating, denormals flushed to zero).
module fr_normalizer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        stall,
  input  logic        in_valid,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [24:0] sum_in,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic        s1_valid;
  logic        s1_sign;
  logic        s1_carry;
  logic        s1_zero;
  logic [7:0]  s1_exp;
  logic [23:0] s1_sum;
  logic [4:0]  s1_lz;
  logic [4:0]  lz_in;

  logic [8:0]  e_inc;
  logic [8:0]  exp9;
  logic [8:0]  lz9;
  logic [7:0]  exp_sh;
  logic [22:0] mant_sh;
  logic [31:0] res_d;
  logic        ovf_d;
  logic        unf_d;

  logic [31:0] res_q;
  logic        ovf_q;
  logic        unf_q;

  // Ascending scan so the highest set bit determines the count.
  always_comb begin
    lz_in = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (sum_in[i]) lz_in = 5'(23 - i);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_carry <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= 8'h0;
      s1_sum   <= 24'h0;
      s1_lz    <= 5'd0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= sign_in;
        s1_carry <= sum_in[24];
        s1_zero  <= (sum_in == 25'h0);
        s1_exp   <= exp_in;
        s1_sum   <= sum_in[23:0];
        s1_lz    <= lz_in;
      end
    end
  end

  // The hidden bit (sum[23]) never survives into the fraction, so a 23-bit
  // shift is enough: for any nonzero shift that bit is already zero.
  always_comb begin
    e_inc   = {1'b0, s1_exp} + 9'd1;
    exp9    = {1'b0, s1_exp};
    lz9     = {4'd0, s1_lz};
    exp_sh  = s1_exp - {3'd0, s1_lz};
    mant_sh = s1_sum[22:0] << s1_lz;
    res_d   = 32'h0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (!s1_zero) begin
      if (s1_carry) begin
        if (e_inc >= 9'd255) begin
          res_d = {s1_sign, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else begin
          res_d = {s1_sign, e_inc[7:0], s1_sum[23:1]};
        end
      end else if (s1_lz == 5'd0 && s1_exp != 8'h0) begin
        res_d = {s1_sign, s1_exp, s1_sum[22:0]};
      end else if (lz9 < exp9) begin
        res_d = {s1_sign, exp_sh, mant_sh};
      end else begin
        res_d = {s1_sign, 31'h0};
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      res_q     <= 32'h0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  // Result holds through bubbles; the flags are only meaningful with out_valid.
  assign result    = res_q;
  assign overflow  = ovf_q & out_valid;
  assign underflow = unf_q & out_valid;

endmodule
